echo_ind_link_tx: RTL and testbench
===================================

Name: echo_ind_link_tx

Overview:
- Transmitter at the far end of the EchoIndication pipe. It accepts one EchoIndication_data message per pipe.enq transaction.
- Each message goes out as a framed stream of 32-bit words on a narrow link: one header word, then the payload words.
- It sits between EchoIndicationOutput's pipe port and the off-chip/host link. A future echo_ind_link_rx is its mirror.

Parameters:
- SYNC, 8'hA5, sync byte placed in header bits [31:24].
- HEARD_TAG, 1, tag value identifying the heard method.
- HEARD_WORDS, 2, payload word count for a heard message (meth, v).

Ports:
- CLK  input  1  clock; all logic is rising-edge.
- RST  input  1  synchronous active-high reset.
- pipe.enq__ENA  input  1  message valid-and-commit strobe (atomicc ENA).
- pipe.enq$v  input  96  EchoIndication_data packed: [95:64] v, [63:32] meth, [31:0] tag.
- pipe.enq__RDY  output  1  block can accept a message this cycle.
- link.enq__ENA  output  1  link word valid.
- link.enq$v  output  32  link word.
- link.enq__RDY  input  1  link sink accepts the word when ENA and RDY are both high.
- msg_count  output  16  messages fully transmitted (wraps).
- bad_tag_count  output  16  messages with unknown tag (wraps).

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: FSM=IDLE, link.enq__ENA=0, link.enq$v=0, pipe.enq__RDY=1, both counters=0.
- RST asserted mid-frame: the frame is abandoned immediately with no further words. The buffered message is lost. No counter is incremented.
- Storage: a single 96-bit message register, loaded on pipe.enq__ENA && pipe.enq__RDY.
- Driving pipe.enq__ENA while pipe.enq__RDY=0 is a protocol violation. The block ignores it; the bench asserts it never happens.
- FSM states:
  - IDLE → HDR on accept.
  - HDR: link word = {SYNC, nwords[7:0], tag[15:0]}. nwords=HEARD_WORDS if tag==HEARD_TAG, else 0.
  - HDR → PAY on handshake if nwords>0; HDR → DONE-path (see below) if nwords=0.
  - PAY: word index idx counts 0..nwords-1. idx=0 sends meth, idx=1 sends v. Advance only on handshake; leave after the last index handshakes.
- link.enq__ENA is 1 in HDR and PAY, 0 in IDLE. It is registered (Moore). link.enq$v holds stable while ENA=1 && RDY=0.
- Latency: first header word appears the cycle after accept. Heard frame = 3 words, minimum 3 cycles with RDY held high.
- Frame completion (last word handshake):
  - msg_count increments.
  - bad_tag_count also increments if the frame was header-only. An unknown tag is still framed as a header-only frame, never dropped.
- Back-to-back:
  - pipe.enq__RDY = (state==IDLE) || (last word of current frame && link.enq__RDY). This is a combinational path from link.enq__RDY.
  - A new message accepted in the completion cycle goes directly to HDR next cycle, with no idle bubble.
- Simultaneous message accept and completion: the counter update applies to the completing frame. The register load applies to the new message.
- Only the low 16 bits of tag are sent in the header. Upper tag bits are ignored for transmission but are fully compared against HEARD_TAG.
- Counters wrap 16'hFFFF → 0 silently.

Decomposition:
- Shared package echo_link_pkg holds:
  - EchoIndication_data and the heard struct typedefs, reused from the generated types.
  - link_hdr_t struct {sync[7:0], nwords[7:0], tag[15:0]}.
  - Constants SYNC_BYTE and HEARD_TAG.
  - FSM enum {IDLE, HDR, PAY}.
- The same package is shared with echo_ind_link_rx.
- No sub-module. The FSM, index counter and two counters are small enough to stay inline.

Test Plan:
- Reset, then one message tag=1 meth=7 v=32'hDEADBEEF with RDY always 1 → words A5020001, 00000007, DEADBEEF on 3 consecutive cycles; msg_count=1.
- Same message with link.enq__RDY toggling 1,0,0,1,0,1 → identical 3-word sequence; each word held stable during stalls; no duplicates or drops.
- Two messages (tag=1 meth=1 v=2, then tag=1 meth=3 v=4) offered back-to-back → second accepted in the cycle the first's v word handshakes; 6 contiguous words; msg_count=2.
- Message tag=5 → single word A5000005; bad_tag_count=1, msg_count=1; pipe.enq__RDY returns high in the completion cycle.
- RST asserted for one cycle after the header handshake of a heard frame → no payload words emitted; outputs at reset values next cycle; counters 0; a fresh message afterwards frames correctly.
- 65536 header-only messages → bad_tag_count and msg_count wrap to 0.

Source files
------------

// File: rtl/echo_link_pkg.sv
// Shared types and constants for the EchoIndication link transmitter and
// its future receiver.
//   EchoIndication_data  : the 96-bit pipe message {v, meth, tag}
//   EchoIndication_heard : payload of the heard method {meth, v}
//   link_hdr_t           : header word layout {sync, nwords, tag[15:0]}
//   tx_state_t           : framing FSM states
package echo_link_pkg;

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] meth;
    logic [31:0] tag;
  } EchoIndication_data;

  typedef struct packed {
    logic [31:0] meth;
    logic [31:0] v;
  } EchoIndication_heard;

  typedef struct packed {
    logic [7:0]  sync;
    logic [7:0]  nwords;
    logic [15:0] tag;
  } link_hdr_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
  localparam logic [31:0] HEARD_TAG   = 32'd1;
  localparam int          HEARD_WORDS = 2;

  typedef enum logic [1:0] {IDLE, HDR, PAY} tx_state_t;

  function automatic link_hdr_t make_hdr(input logic [7:0]  sync,
                                         input logic [7:0]  nwords,
                                         input logic [15:0] tag);
    link_hdr_t h;
    h.sync   = sync;
    h.nwords = nwords;
    h.tag    = tag;
    return h;
  endfunction

endpackage

// File: rtl/echo_ind_link_tx.sv
// EchoIndication link transmitter.
// Takes one EchoIndication_data message per pipe handshake and sends it on a
// 32-bit link as a header word followed by nwords payload words.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   pipe_enq_ena/_v/_rdy      message input (ena commits when rdy is high)
//   link_enq_ena/_v/_rdy      link word output (word taken when ena && rdy)
//   msg_count                 frames fully transmitted (wraps)
//   bad_tag_count             header-only frames, i.e. unknown tag (wraps)
module echo_ind_link_tx #(
  parameter logic [7:0]  SYNC        = echo_link_pkg::SYNC_BYTE,
  parameter logic [31:0] HEARD_TAG   = echo_link_pkg::HEARD_TAG,
  parameter int          HEARD_WORDS = echo_link_pkg::HEARD_WORDS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pipe_enq_ena,
  input  logic [95:0] pipe_enq_v,
  output logic        pipe_enq_rdy,
  output logic        link_enq_ena,
  output logic [31:0] link_enq_v,
  input  logic        link_enq_rdy,
  output logic [15:0] msg_count,
  output logic [15:0] bad_tag_count
);
  import echo_link_pkg::*;

  localparam logic [7:0] HEARD_NW = 8'(HEARD_WORDS);

  tx_state_t          state_reg;
  EchoIndication_data msg_reg;
  logic [7:0]         idx_reg;
  logic               link_ena_reg;
  logic [31:0]        link_v_reg;
  logic [15:0]        msg_count_reg;
  logic [15:0]        bad_count_reg;

  EchoIndication_data in_msg;
  logic [7:0]         cur_nwords;
  logic               last_word;
  logic               link_hs;
  logic               frame_done;
  logic               accept;

  // The full 32-bit tag is compared; only the low half goes on the wire.
  function automatic logic [7:0] nwords_of(input EchoIndication_data m);
    return (m.tag == HEARD_TAG) ? HEARD_NW : 8'd0;
  endfunction

  function automatic logic [31:0] hdr_word(input EchoIndication_data m);
    return make_hdr(SYNC, nwords_of(m), m.tag[15:0]);
  endfunction

  function automatic logic [31:0] payload_word(input EchoIndication_data m,
                                               input logic [7:0] idx);
    return (idx == 8'd0) ? m.meth : m.v;
  endfunction

  assign in_msg     = pipe_enq_v;
  assign cur_nwords = nwords_of(msg_reg);
  assign last_word  = ((state_reg == HDR) && (cur_nwords == 8'd0)) ||
                      ((state_reg == PAY) && (idx_reg == cur_nwords - 8'd1));
  assign link_hs    = link_ena_reg && link_enq_rdy;
  assign frame_done = link_hs && last_word;

  // Ready in the completion cycle lets the next frame start with no bubble;
  // this is deliberately combinational from link_enq_rdy.
  assign pipe_enq_rdy = (state_reg == IDLE) || (last_word && link_enq_rdy);
  assign accept       = pipe_enq_ena && pipe_enq_rdy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      msg_reg       <= '0;
      idx_reg       <= 8'd0;
      link_ena_reg  <= 1'b0;
      link_v_reg    <= 32'd0;
      msg_count_reg <= 16'd0;
      bad_count_reg <= 16'd0;
    end else begin
      // Counters belong to the frame that completes, even if a new message
      // is loaded in the same cycle.
      if (frame_done) begin
        msg_count_reg <= msg_count_reg + 16'd1;
        if (cur_nwords == 8'd0) begin
          bad_count_reg <= bad_count_reg + 16'd1;
        end
      end

      // accept can only be true in IDLE or in the completion cycle.
      if (accept) begin
        msg_reg      <= in_msg;
        state_reg    <= HDR;
        idx_reg      <= 8'd0;
        link_ena_reg <= 1'b1;
        link_v_reg   <= hdr_word(in_msg);
      end else if (frame_done) begin
        state_reg    <= IDLE;
        link_ena_reg <= 1'b0;
      end else if (link_hs) begin
        if (state_reg == HDR) begin
          state_reg  <= PAY;
          idx_reg    <= 8'd0;
          link_v_reg <= payload_word(msg_reg, 8'd0);
        end else begin
          idx_reg    <= idx_reg + 8'd1;
          link_v_reg <= payload_word(msg_reg, idx_reg + 8'd1);
        end
      end
    end
  end

  assign link_enq_ena  = link_ena_reg;
  assign link_enq_v    = link_v_reg;
  assign msg_count     = msg_count_reg;
  assign bad_tag_count = bad_count_reg;

endmodule

// File: tb/tb_echo_ind_link_tx.sv
// Self-checking bench for echo_ind_link_tx. Expected link words are pushed to
// a scoreboard queue when a message is offered and popped by a monitor on
// every link handshake.
module tb_echo_ind_link_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0;
  logic        pipe_ena;
  logic [95:0] pipe_v = '0;
  logic        pipe_rdy;
  logic        link_ena;
  logic [31:0] link_v;
  logic        link_rdy = 1'b1;
  logic [15:0] msg_count;
  logic [15:0] bad_tag_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_cnt       = 0;
  int cyc          = 0;
  int rdy_base     = 0;
  int rdy_len      = 1;
  logic [15:0] rdy_pat = 16'hFFFF;

  logic [31:0] sb[$];

  // ENA is only ever raised while the block is ready.
  assign pipe_ena = req && pipe_rdy;

  always #5 CLK = ~CLK;

  echo_ind_link_tx dut (
    .CLK          (CLK),
    .RST          (RST),
    .pipe_enq_ena (pipe_ena),
    .pipe_enq_v   (pipe_v),
    .pipe_enq_rdy (pipe_rdy),
    .link_enq_ena (link_ena),
    .link_enq_v   (link_v),
    .link_enq_rdy (link_rdy),
    .msg_count    (msg_count),
    .bad_tag_count(bad_tag_count)
  );

  function automatic logic [31:0] exp_hdr(input logic [31:0] tag);
    logic [7:0] nw;
    nw = (tag == 32'd1) ? 8'd2 : 8'd0;
    return {8'hA5, nw, tag[15:0]};
  endfunction

  task automatic push_msg(input logic [31:0] tag, input logic [31:0] meth,
                          input logic [31:0] v);
    sb.push_back(exp_hdr(tag));
    if (tag == 32'd1) begin
      sb.push_back(meth);
      sb.push_back(v);
    end
  endtask

  task automatic rdy_driver();
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      link_rdy = rdy_pat[(cyc - rdy_base) % rdy_len];
    end
  endtask

  task automatic set_rdy(input logic [15:0] pat, input int len);
    rdy_pat  = pat;
    rdy_len  = len;
    rdy_base = cyc + 1;
  endtask

  task automatic monitor();
    logic        prev_stall = 1'b0;
    logic [31:0] prev_v = 32'd0;
    logic [31:0] exp_w;
    forever begin
      @(negedge CLK);
      assert (!(pipe_ena && !pipe_rdy));
      if (RST) begin
        prev_stall = 1'b0;
      end else begin
        if (link_ena && link_rdy) begin
          hs_cnt++;
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL link_word: got unexpected %08h, required no word", link_v);
          end else begin
            exp_w = sb.pop_front();
            if (link_v !== exp_w) begin
              tests_failed++;
              $display("FAIL link_word: got %08h, required %08h", link_v, exp_w);
            end
          end
        end
        if (prev_stall && link_ena) begin
          tests_run++;
          if (link_v !== prev_v) begin
            tests_failed++;
            $display("FAIL stall_hold: got %08h, required %08h", link_v, prev_v);
          end
        end
        prev_stall = link_ena && !link_rdy;
        prev_v     = link_v;
      end
    end
  endtask

  task automatic do_reset();
    req = 1'b0;
    RST = 1'b1;
    sb.delete();
    set_rdy(16'hFFFF, 1);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic send_msg(input logic [31:0] tag, input logic [31:0] meth,
                          input logic [31:0] v, output logic acc_ok,
                          output logic [31:0] acc_v, output logic acc_hs);
    push_msg(tag, meth, v);
    pipe_v = {v, meth, tag};
    req    = 1'b1;
    acc_ok = 1'b0;
    acc_v  = 32'd0;
    acc_hs = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (pipe_rdy) begin
        acc_ok = 1'b1;
        acc_v  = link_v;
        acc_hs = link_ena && link_rdy;
        break;
      end
    end
    if (!acc_ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: got pipe_rdy=0 for 200 cycles, required 1");
      req = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      req = 1'b0;
    end
    $display("[TB] msg tag=%08h meth=%08h v=%08h accepted=%0b", tag, meth, v, acc_ok);
  endtask

  task automatic wait_drain(input int max_cycles);
    logic done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !link_ena) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", sb.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_counts(input string name, input logic [15:0] exp_msg,
                              input logic [15:0] exp_bad);
    tests_run++;
    if (msg_count !== exp_msg) begin
      tests_failed++;
      $display("FAIL %s msg_count: got %0d, required %0d", name, msg_count, exp_msg);
    end
    tests_run++;
    if (bad_tag_count !== exp_bad) begin
      tests_failed++;
      $display("FAIL %s bad_tag_count: got %0d, required %0d", name, bad_tag_count, exp_bad);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests_run++;
    if (link_ena !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s link_ena: got %b, required 0", name, link_ena);
    end
    tests_run++;
    if (link_v !== 32'd0) begin
      tests_failed++;
      $display("FAIL %s link_v: got %08h, required 00000000", name, link_v);
    end
    tests_run++;
    if (pipe_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s pipe_rdy: got %b, required 1", name, pipe_rdy);
    end
    check_counts(name, 16'd0, 16'd0);
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_heard_basic();
    logic ok, hs;
    logic [31:0] av;
    int hs0;
    do_reset();
    send_msg(32'd1, 32'd7, 32'hDEADBEEF, ok, av, hs);
    tests_run++;
    if (link_ena !== 1'b1 || link_v !== 32'hA5020001) begin
      tests_failed++;
      $display("FAIL heard_latency: got ena=%b word=%08h, required ena=1 word=A5020001",
               link_ena, link_v);
    end
    hs0 = hs_cnt;
    repeat (3) @(negedge CLK);
    #1;
    tests_run++;
    if (hs_cnt - hs0 !== 3) begin
      tests_failed++;
      $display("FAIL heard_contiguous: got %0d words in 3 cycles, required 3", hs_cnt - hs0);
    end
    wait_drain(50);
    check_counts("heard", 16'd1, 16'd0);
  endtask

  task automatic test_stall();
    logic ok, hs;
    logic [31:0] av;
    int hs0;
    do_reset();
    set_rdy(16'b101001, 6);  // 1,0,0,1,0,1 in time order
    hs0 = hs_cnt;
    send_msg(32'd1, 32'd7, 32'hDEADBEEF, ok, av, hs);
    wait_drain(100);
    tests_run++;
    if (hs_cnt - hs0 !== 3) begin
      tests_failed++;
      $display("FAIL stall_word_count: got %0d, required 3", hs_cnt - hs0);
    end
    check_counts("stall", 16'd1, 16'd0);
    set_rdy(16'hFFFF, 1);
  endtask

  task automatic test_back_to_back();
    logic ok, hs;
    logic [31:0] av;
    int hs0;
    do_reset();
    send_msg(32'd1, 32'd1, 32'd2, ok, av, hs);
    hs0 = hs_cnt;
    send_msg(32'd1, 32'd3, 32'd4, ok, av, hs);
    tests_run++;
    if (!ok || av !== 32'd2 || hs !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept_cycle: got ok=%b word=%08h hs=%b, required ok=1 word=00000002 hs=1",
               ok, av, hs);
    end
    repeat (3) @(negedge CLK);
    #1;
    tests_run++;
    if (hs_cnt - hs0 !== 6) begin
      tests_failed++;
      $display("FAIL b2b_contiguous: got %0d words in 6 cycles, required 6", hs_cnt - hs0);
    end
    wait_drain(50);
    check_counts("b2b", 16'd2, 16'd0);
  endtask

  task automatic test_bad_tag();
    logic ok, hs;
    logic [31:0] av;
    do_reset();
    send_msg(32'd5, 32'd0, 32'd0, ok, av, hs);
    @(negedge CLK);
    tests_run++;
    if (link_ena !== 1'b1 || link_v !== 32'hA5000005 || pipe_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bad_tag_completion: got ena=%b word=%08h pipe_rdy=%b, required ena=1 word=A5000005 pipe_rdy=1",
               link_ena, link_v, pipe_rdy);
    end
    wait_drain(50);
    check_counts("bad_tag", 16'd1, 16'd1);
    // Upper tag bits must defeat the heard match.
    send_msg(32'h0001_0001, 32'd9, 32'd9, ok, av, hs);
    wait_drain(50);
    check_counts("bad_tag_upper", 16'd2, 16'd2);
  endtask

  task automatic test_reset_midframe();
    logic ok, hs;
    logic [31:0] av;
    logic seen = 1'b0;
    int hs_mid;
    do_reset();
    send_msg(32'd1, 32'd7, 32'd8, ok, av, hs);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (link_ena && link_rdy) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL midframe_header: got no header handshake, required one");
    end
    set_rdy(16'h0000, 1);
    @(posedge CLK);
    #1;
    RST    = 1'b1;
    hs_mid = hs_cnt;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_idle_outputs("midframe_reset");
    tests_run++;
    if (hs_cnt !== hs_mid) begin
      tests_failed++;
      $display("FAIL midframe_payload: got %0d payload words, required 0", hs_cnt - hs_mid);
    end
    sb.delete();
    set_rdy(16'hFFFF, 1);
    repeat (2) @(posedge CLK);
    #1;
    send_msg(32'd1, 32'h11, 32'h22, ok, av, hs);
    wait_drain(50);
    check_counts("after_midframe", 16'd1, 16'd0);
  endtask

  task automatic test_wrap();
    logic ok, hs;
    logic [31:0] av;
    logic got;
    do_reset();
    pipe_v = {32'd0, 32'd0, 32'd5};
    req    = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      push_msg(32'd5, 32'd0, 32'd0);
      got = 1'b0;
      for (int j = 0; j < 20; j++) begin
        @(negedge CLK);
        if (pipe_rdy) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        tests_run++;
        tests_failed++;
        $display("FAIL wrap_accept: got pipe_rdy=0 at message %0d, required 1", i);
        break;
      end
      @(posedge CLK);
      #1;
    end
    req = 1'b0;
    wait_drain(100);
    $display("[TB] wrap burst of 65535 header-only messages done");
    check_counts("wrap_max", 16'hFFFF, 16'hFFFF);
    send_msg(32'd5, 32'd0, 32'd0, ok, av, hs);
    wait_drain(50);
    check_counts("wrap_zero", 16'd0, 16'd0);
  endtask

  initial begin
    fork
      rdy_driver();
      monitor();
      begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_heard_basic();
    test_stall();
    test_back_to_back();
    test_bad_tag();
    test_reset_midframe();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
